pswitch_core: RTL

Parametrised N-port packet switch core, the next-generation DUT behind the testbench interface. Each input port presents an address/data word with a valid/ready handshake. The word is routed to a per-output FIFO selected by its address, with round-robin arbitration when several inputs target the same output. Receivers drain each output with the existing `rcv_rdy`/`data_rd` handshake. The block generalises the fixed 4-port, 8-bit switch in port count, field widths and queue depth, and adds input backpressure and drop accounting.

---
 rtl/pswitch_pkg.sv | 19 +
 rtl/pswitch_if.sv | 30 +++
 rtl/pswitch_fifo.sv | 54 +++++
 rtl/pswitch_core.sv | 129 ++++++++++++
 4 files changed

// File: rtl/pswitch_pkg.sv
// Shared constants, helpers and entry type for the N-port packet switch.
package pswitch_pkg;

   localparam int NPORTS_DEF = 4;
   localparam int AW_DEF     = 8;
   localparam int DW_DEF     = 8;
   localparam int DEPTH_DEF  = 4;
   localparam int CNTW_DEF   = 16;

   function automatic int port_w(input int n);
      return $clog2(n);
   endfunction

   typedef struct packed {
      logic [AW_DEF-1:0] addr;
      logic [DW_DEF-1:0] data;
   } entry_t;

endpackage

// File: rtl/pswitch_if.sv
// Input/output handshake bundle of the packet switch; per-port fields are packed side by side.
interface pswitch_if
   import pswitch_pkg::*;
#(
   parameter int NPORTS = NPORTS_DEF,
   parameter int AW     = AW_DEF,
   parameter int DW     = DW_DEF,
   parameter int CNTW   = CNTW_DEF
);
   logic [NPORTS*AW-1:0] addr_in;
   logic [NPORTS*DW-1:0] data_in;
   logic [NPORTS-1:0]    valid_in;
   logic [NPORTS-1:0]    in_rdy;
   logic [NPORTS-1:0]    rcv_rdy;
   logic [NPORTS-1:0]    data_rd;
   logic [NPORTS*AW-1:0] addr_out;
   logic [NPORTS*DW-1:0] data_out;
   logic [NPORTS-1:0]    valid_out;
   logic [CNTW-1:0]      drop_cnt;

   modport master (
      output addr_in, data_in, valid_in, data_rd,
      input  in_rdy, rcv_rdy, addr_out, data_out, valid_out, drop_cnt
   );

   modport slave (
      input  addr_in, data_in, valid_in, data_rd,
      output in_rdy, rcv_rdy, addr_out, data_out, valid_out, drop_cnt
   );
endinterface

// File: rtl/pswitch_fifo.sv
// Per-output synchronous FIFO; read data and read strobe are registered one cycle after pop.
module pswitch_fifo #(
   parameter int W     = 16,
   parameter int DEPTH = 4
)(
   input  logic         clk,
   input  logic         reset,
   input  logic         push,
   input  logic         pop,
   input  logic [W-1:0] wdata,
   output logic         full,
   output logic         empty,
   output logic [W-1:0] rdata,
   output logic         rvalid
);
   localparam int IW = $clog2(DEPTH);
   localparam logic [IW:0] PTR_ONE = (IW+1)'(1);

   logic [W-1:0] mem [DEPTH];
   logic [IW:0]  wr_ptr_reg, rd_ptr_reg;
   logic [W-1:0] rdata_reg;
   logic         rvalid_reg;
   logic         do_push, do_pop;

   // Extra pointer MSB separates full (MSBs differ) from empty (pointers equal).
   assign empty   = (wr_ptr_reg == rd_ptr_reg);
   assign full    = (wr_ptr_reg[IW] != rd_ptr_reg[IW]) &&
                    (wr_ptr_reg[IW-1:0] == rd_ptr_reg[IW-1:0]);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign rdata   = rdata_reg;
   assign rvalid  = rvalid_reg;

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr_reg[IW-1:0]] <= wdata;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         rdata_reg  <= '0;
         rvalid_reg <= 1'b0;
      end else begin
         if (do_push) wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
         if (do_pop) begin
            rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
            rdata_reg  <= mem[rd_ptr_reg[IW-1:0]];
         end
         rvalid_reg <= do_pop;
      end
   end

endmodule

// File: rtl/pswitch_core.sv
// N-port packet switch: address decode, per-output round-robin arbiters feeding
// per-output FIFOs, and a saturating counter of words dropped for illegal addresses.
module pswitch_core
   import pswitch_pkg::*;
#(
   parameter int NPORTS = NPORTS_DEF,
   parameter int AW     = AW_DEF,
   parameter int DW     = DW_DEF,
   parameter int DEPTH  = DEPTH_DEF,
   parameter int CNTW   = CNTW_DEF
)(
   input logic      clk,
   input logic      reset,
   pswitch_if.slave bus
);
   localparam int PW = port_w(NPORTS);
   localparam int EW = AW + DW;
   localparam int SW = ((CNTW > 5) ? CNTW : 5) + 1;
   localparam logic [CNTW-1:0] CNT_MAX = '1;

   logic [AW-1:0]     addr_i [NPORTS];
   logic [DW-1:0]     data_i [NPORTS];
   logic [NPORTS-1:0] legal;
   logic [NPORTS-1:0] grant_vec [NPORTS];
   logic [EW-1:0]     rd_data [NPORTS];
   logic              rd_valid [NPORTS];
   logic              not_empty [NPORTS];
   logic [NPORTS-1:0] in_rdy;
   logic [CNTW-1:0]   drop_cnt_reg, drop_cnt_next;
   logic [4:0]        drop_n;
   logic [SW-1:0]     drop_sum;

   // A word is legal exactly when its whole address is a valid port number.
   always_comb begin
      legal = '0;
      for (int i = 0; i < NPORTS; i++) begin
         addr_i[i] = bus.addr_in[i*AW +: AW];
         data_i[i] = bus.data_in[i*DW +: DW];
         legal[i]  = ({1'b0, addr_i[i]} < (AW+1)'(NPORTS));
      end
   end

   genvar gi;
   for (gi = 0; gi < NPORTS; gi++) begin : g_out
      logic [NPORTS-1:0] req;
      logic [NPORTS-1:0] grant;
      logic              gnt, full, empty;
      logic [EW-1:0]     push_data;
      logic [PW-1:0]     rr_ptr_reg, rr_next;

      always_comb begin
         int idx;
         idx       = 0;
         req       = '0;
         grant     = '0;
         gnt       = 1'b0;
         push_data = '0;
         rr_next   = rr_ptr_reg;
         for (int i = 0; i < NPORTS; i++)
            req[i] = bus.valid_in[i] && legal[i] && (addr_i[i][PW-1:0] == PW'(gi));
         if (!full) begin
            for (int k = 0; k < NPORTS; k++) begin
               idx = (int'(rr_ptr_reg) + k) % NPORTS;
               if (!gnt && req[idx]) begin
                  gnt        = 1'b1;
                  grant[idx] = 1'b1;
                  push_data  = {addr_i[idx], data_i[idx]};
                  rr_next    = PW'((idx + 1) % NPORTS);
               end
            end
         end
      end

      always_ff @(posedge clk or negedge reset) begin
         if (!reset)   rr_ptr_reg <= '0;
         else if (gnt) rr_ptr_reg <= rr_next;
      end

      assign grant_vec[gi] = grant;
      assign not_empty[gi] = !empty;

      pswitch_fifo #(.W(EW), .DEPTH(DEPTH)) u_fifo (
         .clk    (clk),
         .reset  (reset),
         .push   (gnt),
         .pop    (bus.data_rd[gi]),
         .wdata  (push_data),
         .full   (full),
         .empty  (empty),
         .rdata  (rd_data[gi]),
         .rvalid (rd_valid[gi])
      );
   end

   // Illegal words are always taken (and dropped); legal ones only on a grant.
   always_comb begin
      in_rdy = ~legal;
      for (int j = 0; j < NPORTS; j++) in_rdy = in_rdy | grant_vec[j];
   end

   always_comb begin
      drop_n = '0;
      for (int i = 0; i < NPORTS; i++)
         if (bus.valid_in[i] && !legal[i]) drop_n = drop_n + 5'd1;
      drop_sum      = SW'(drop_cnt_reg) + SW'(drop_n);
      drop_cnt_next = (drop_sum > SW'(CNT_MAX)) ? CNT_MAX : drop_sum[CNTW-1:0];
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) drop_cnt_reg <= '0;
      else        drop_cnt_reg <= drop_cnt_next;
   end

   always_comb begin
      bus.in_rdy    = in_rdy;
      bus.drop_cnt  = drop_cnt_reg;
      bus.rcv_rdy   = '0;
      bus.valid_out = '0;
      bus.addr_out  = '0;
      bus.data_out  = '0;
      for (int j = 0; j < NPORTS; j++) begin
         bus.rcv_rdy[j]            = not_empty[j];
         bus.valid_out[j]          = rd_valid[j];
         bus.addr_out[j*AW +: AW]  = rd_data[j][EW-1:DW];
         bus.data_out[j*DW +: DW]  = rd_data[j][DW-1:0];
      end
   end

endmodule
